// File: rtl/ni_route_lookup_sequencer_if.sv
// Bundle of request, routing-LUT, header, write-sink and error-response signals
// between an NI initiator front end and the route lookup sequencer.
interface ni_route_lookup_sequencer_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int PATH_WIDTH  = 7,
    parameter int TGT_WIDTH   = 4,
    parameter int BURST_WIDTH = 4
) ();
    logic                   req_valid;
    logic                   req_ready;
    logic [2:0]             req_cmd;
    logic [ADDR_WIDTH-1:0]  req_addr;
    logic [BURST_WIDTH-1:0] req_burst;

    logic [ADDR_WIDTH-1:0]  lut_address;
    logic [PATH_WIDTH-1:0]  lut_path;
    logic [TGT_WIDTH-1:0]   transaction_target;
    logic                   failed_decoding;

    logic                   hdr_valid;
    logic                   hdr_ready;
    logic [PATH_WIDTH-1:0]  hdr_path;
    logic [TGT_WIDTH-1:0]   hdr_target;
    logic [ADDR_WIDTH-1:0]  hdr_addr;
    logic [2:0]             hdr_cmd;
    logic [BURST_WIDTH-1:0] hdr_burst;

    logic                   drop_valid;
    logic                   drop_ready;

    logic                   err_valid;
    logic                   err_ready;
    logic [2:0]             err_cmd;

    // Environment side: issues requests, answers LUT lookups, consumes headers/errors.
    modport master (
        output req_valid, req_cmd, req_addr, req_burst,
        output lut_path, transaction_target, failed_decoding,
        output hdr_ready, drop_valid, err_ready,
        input  req_ready, lut_address,
        input  hdr_valid, hdr_path, hdr_target, hdr_addr, hdr_cmd, hdr_burst,
        input  drop_ready, err_valid, err_cmd
    );

    modport slave (
        input  req_valid, req_cmd, req_addr, req_burst,
        input  lut_path, transaction_target, failed_decoding,
        input  hdr_ready, drop_valid, err_ready,
        output req_ready, lut_address,
        output hdr_valid, hdr_path, hdr_target, hdr_addr, hdr_cmd, hdr_burst,
        output drop_ready, err_valid, err_cmd
    );
endinterface

// File: rtl/ni_route_lookup_sequencer.sv
// Single-outstanding address-decode sequencer for an NI initiator: looks up the route,
// hands a header to the packetizer, or sinks write beats and answers locally on a miss.
module ni_route_lookup_sequencer #(
    parameter int ADDR_WIDTH  = 32,
    parameter int PATH_WIDTH  = 7,
    parameter int TGT_WIDTH   = 4,
    parameter int BURST_WIDTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    ni_route_lookup_sequencer_if.slave    bus,
    output logic                          busy,
    output logic [7:0]                    err_count
);
    localparam logic [2:0] CMD_WR = 3'd1;
    localparam logic [2:0] CMD_RD = 3'd2;

    typedef enum logic [2:0] {IDLE, LOOKUP, SEND, DRAIN, ERR_RESP} state_t;

    state_t                 state_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [2:0]             cmd_q;
    logic [BURST_WIDTH-1:0] burst_q;
    logic [BURST_WIDTH-1:0] beats_q;
    logic [PATH_WIDTH-1:0]  path_q;
    logic [TGT_WIDTH-1:0]   tgt_q;
    logic [2:0]             err_cmd_q;
    logic [7:0]             err_count_q;
    logic                   req_ready_q;
    logic                   hdr_valid_q;
    logic                   drop_ready_q;
    logic                   err_valid_q;
    logic                   busy_q;
    logic                   req_take;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [BURST_WIDTH-1:0] norm_burst(input logic [BURST_WIDTH-1:0] b);
        return (b == '0) ? BURST_WIDTH'(1) : b;
    endfunction

    assign req_take = bus.req_valid && (bus.req_cmd == CMD_WR || bus.req_cmd == CMD_RD);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            cmd_q        <= '0;
            burst_q      <= '0;
            beats_q      <= '0;
            path_q       <= '0;
            tgt_q        <= '0;
            err_cmd_q    <= '0;
            err_count_q  <= '0;
            req_ready_q  <= 1'b1;
            hdr_valid_q  <= 1'b0;
            drop_ready_q <= 1'b0;
            err_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_take) begin
                        addr_q      <= bus.req_addr;
                        cmd_q       <= bus.req_cmd;
                        burst_q     <= norm_burst(bus.req_burst);
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    // The LUT is combinational on addr_q, so its answer is valid throughout this cycle.
                    if (!bus.failed_decoding) begin
                        path_q      <= bus.lut_path;
                        tgt_q       <= bus.transaction_target;
                        hdr_valid_q <= 1'b1;
                        state_q     <= SEND;
                    end else begin
                        err_count_q <= sat_inc(err_count_q);
                        if (cmd_q == CMD_WR) begin
                            beats_q      <= burst_q;
                            drop_ready_q <= 1'b1;
                            state_q      <= DRAIN;
                        end else begin
                            err_cmd_q   <= cmd_q;
                            err_valid_q <= 1'b1;
                            state_q     <= ERR_RESP;
                        end
                    end
                end
                SEND: begin
                    if (bus.hdr_ready) begin
                        hdr_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                DRAIN: begin
                    // Counting down to 1 rather than 0 keeps a full-scale burst from wrapping.
                    if (bus.drop_valid) begin
                        if (beats_q == BURST_WIDTH'(1)) begin
                            drop_ready_q <= 1'b0;
                            err_cmd_q    <= cmd_q;
                            err_valid_q  <= 1'b1;
                            state_q      <= ERR_RESP;
                        end else begin
                            beats_q <= beats_q - BURST_WIDTH'(1);
                        end
                    end
                end
                ERR_RESP: begin
                    if (bus.err_ready) begin
                        err_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.lut_address = addr_q;
    assign bus.hdr_valid   = hdr_valid_q;
    assign bus.hdr_path    = path_q;
    assign bus.hdr_target  = tgt_q;
    assign bus.hdr_addr    = addr_q;
    assign bus.hdr_cmd     = cmd_q;
    assign bus.hdr_burst   = burst_q;
    assign bus.drop_ready  = drop_ready_q;
    assign bus.err_valid   = err_valid_q;
    assign bus.err_cmd     = err_cmd_q;
    assign busy            = busy_q;
    assign err_count       = err_count_q;
endmodule

// File: tb/tb_ni_route_lookup_sequencer.sv
// Bench for ni_route_lookup_sequencer: transaction-level expectations checked every cycle,
// directed scenarios followed by randomized traffic.
module tb_ni_route_lookup_sequencer;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       busy;
    logic [7:0] err_count;

    int vectors     = 0;
    int miscompares = 0;
    bit run_chk     = 1'b0;

    // Expected externally visible state, advanced by the stimulus at transaction milestones.
    logic [31:0] exp_addr;
    logic [2:0]  exp_cmd;
    logic [3:0]  exp_burst;
    logic [6:0]  exp_path;
    logic [3:0]  exp_tgt;
    int          exp_errcnt;
    bit          exp_idle, exp_hdr_win, exp_drop_win, exp_err_win;
    logic [2:0]  obs_err_cmd;

    ni_route_lookup_sequencer_if #(.ADDR_WIDTH(32), .PATH_WIDTH(7), .TGT_WIDTH(4), .BURST_WIDTH(4)) bus ();

    ni_route_lookup_sequencer #(.ADDR_WIDTH(32), .PATH_WIDTH(7), .TGT_WIDTH(4), .BURST_WIDTH(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .busy      (busy),
        .err_count (err_count)
    );

    always #5 clock = ~clock;

    function automatic bit lut_miss(input logic [31:0] a);
        return a[31:24] == 8'h00;
    endfunction
    function automatic logic [6:0] lut_p(input logic [31:0] a);
        return a[30:24] ^ 7'h1B;
    endfunction
    function automatic logic [3:0] lut_t(input logic [31:0] a);
        return a[23:20] ^ 4'hC;
    endfunction

    // Routing LUT stand-in: answers whatever address the sequencer presents.
    assign bus.lut_path           = lut_p(bus.lut_address);
    assign bus.transaction_target = lut_t(bus.lut_address);
    assign bus.failed_decoding    = lut_miss(bus.lut_address);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_addr = '0; exp_cmd = '0; exp_burst = '0; exp_path = '0; exp_tgt = '0;
        exp_errcnt = 0; exp_idle = 1; exp_hdr_win = 0; exp_drop_win = 0; exp_err_win = 0;
    endtask

    always @(negedge clock) begin
        if (run_chk && !reset) begin
            chk("req_ready",   {31'd0, bus.req_ready},  {31'd0, exp_idle});
            chk("busy",        {31'd0, busy},           {31'd0, !exp_idle});
            chk("hdr_valid",   {31'd0, bus.hdr_valid},  {31'd0, exp_hdr_win});
            chk("drop_ready",  {31'd0, bus.drop_ready}, {31'd0, exp_drop_win});
            chk("err_valid",   {31'd0, bus.err_valid},  {31'd0, exp_err_win});
            chk("err_count",   {24'd0, err_count},      exp_errcnt);
            chk("lut_address", bus.lut_address,         exp_addr);
            chk("hdr_addr",    bus.hdr_addr,            exp_addr);
            chk("hdr_cmd",     {29'd0, bus.hdr_cmd},    {29'd0, exp_cmd});
            chk("hdr_burst",   {28'd0, bus.hdr_burst},  {28'd0, exp_burst});
            chk("hdr_path",    {25'd0, bus.hdr_path},   {25'd0, exp_path});
            chk("hdr_target",  {28'd0, bus.hdr_target}, {28'd0, exp_tgt});
            if (exp_err_win) chk("err_cmd", {29'd0, bus.err_cmd}, {29'd0, exp_cmd});
        end
    end

    task automatic reset_pulse();
        reset = 1'b1;
        model_reset();
        bus.req_valid = 0; bus.hdr_ready = 0; bus.drop_valid = 0; bus.err_ready = 0;
        #1;
        chk("rst_hdr_valid",  {31'd0, bus.hdr_valid},  32'd0);
        chk("rst_drop_ready", {31'd0, bus.drop_ready}, 32'd0);
        chk("rst_err_valid",  {31'd0, bus.err_valid},  32'd0);
        chk("rst_req_ready",  {31'd0, bus.req_ready},  32'd1);
        chk("rst_busy",       {31'd0, busy},           32'd0);
        chk("rst_err_count",  {24'd0, err_count},      32'd0);
        #2;
        reset = 1'b0;
    endtask

    // One request from IDLE to completion. drop_mode 1 = drop_valid 1,0,1,0,...; abort = reset one
    // cycle into SEND/DRAIN.
    task automatic txn(input logic [2:0] cmd, input logic [31:0] addr, input logic [3:0] burst,
                       input int stall, input int drop_mode, input bit abort);
        bit miss;
        int nb, got, guard;
        bus.hdr_ready = 0; bus.err_ready = 0; bus.drop_valid = 0;
        bus.req_valid = 1; bus.req_cmd = cmd; bus.req_addr = addr; bus.req_burst = burst;
        @(posedge clock); #1;
        // Keep a live-looking request on the bus while busy; it must not be taken.
        bus.req_addr  = $urandom;
        bus.req_burst = 4'($urandom);
        bus.req_cmd   = 3'($urandom_range(1, 2));
        if (cmd != 3'd1 && cmd != 3'd2) begin
            bus.req_valid = 0;
            return;
        end
        exp_addr  = addr;
        exp_cmd   = cmd;
        exp_burst = (burst == 4'd0) ? 4'd1 : burst;
        exp_idle  = 0;
        miss = lut_miss(addr);
        nb   = int'(exp_burst);
        @(posedge clock); #1;
        if (!miss) begin
            exp_path = lut_p(addr); exp_tgt = lut_t(addr); exp_hdr_win = 1;
        end else begin
            if (exp_errcnt < 255) exp_errcnt++;
            if (cmd == 3'd1) exp_drop_win = 1; else exp_err_win = 1;
        end
        if (abort) begin
            @(posedge clock); #1;
            reset_pulse();
            return;
        end
        if (!miss) begin
            repeat (stall) begin @(posedge clock); #1; end
            bus.hdr_ready = 1;
            @(posedge clock); #1;
            bus.hdr_ready = 0; bus.req_valid = 0; exp_hdr_win = 0; exp_idle = 1;
            return;
        end
        if (cmd == 3'd1) begin
            got = 0; guard = 0;
            while (got < nb) begin
                if (drop_mode == 1) bus.drop_valid = (guard % 2 == 0);
                else                bus.drop_valid = (guard > 40) ? 1'b1 : 1'($urandom_range(0, 1));
                @(posedge clock); #1;
                if (bus.drop_valid) got++;
                guard++;
            end
            exp_drop_win = 0; exp_err_win = 1;
        end
        bus.drop_valid = 1;
        repeat (stall) begin @(posedge clock); #1; end
        obs_err_cmd   = bus.err_cmd;
        bus.err_ready = 1;
        @(posedge clock); #1;
        bus.err_ready = 0; bus.drop_valid = 0; bus.req_valid = 0;
        exp_err_win = 0; exp_idle = 1;
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  c;
        model_reset();
        obs_err_cmd = '0;
        bus.req_valid = 0; bus.req_cmd = '0; bus.req_addr = '0; bus.req_burst = '0;
        bus.hdr_ready = 0; bus.drop_valid = 0; bus.err_ready = 0;
        repeat (2) @(posedge clock);
        #1;
        chk("init_req_ready",   {31'd0, bus.req_ready}, 32'd1);
        chk("init_hdr_valid",   {31'd0, bus.hdr_valid}, 32'd0);
        chk("init_lut_address", bus.lut_address,        32'd0);
        chk("init_hdr_path",    {25'd0, bus.hdr_path},  32'd0);
        chk("init_err_count",   {24'd0, err_count},     32'd0);
        chk("init_busy",        {31'd0, busy},          32'd0);
        #2;
        reset = 1'b0;
        run_chk = 1'b1;

        txn(3'd2, 32'h1A00_0000, 4'd4, 3, 0, 0);
        chk("t1_path",   {25'd0, bus.hdr_path},   32'h01);
        chk("t1_target", {28'd0, bus.hdr_target}, 32'hC);
        chk("t1_cmd",    {29'd0, bus.hdr_cmd},    32'd2);
        chk("t1_burst",  {28'd0, bus.hdr_burst},  32'd4);

        txn(3'd2, 32'h0000_1000, 4'd2, 1, 0, 0);
        chk("t2_err_count", {24'd0, err_count},   32'd1);
        chk("t2_err_cmd",   {29'd0, obs_err_cmd}, 32'd2);

        txn(3'd1, 32'h00F0_0000, 4'd3, 2, 1, 0);
        chk("t3_err_count", {24'd0, err_count},   32'd2);
        chk("t3_err_cmd",   {29'd0, obs_err_cmd}, 32'd1);
        chk("t3_path_kept", {25'd0, bus.hdr_path}, 32'h01);

        txn(3'd1, 32'h00AB_C000, 4'd0, 0, 0, 0);
        chk("t4_err_count", {24'd0, err_count}, 32'd3);
        txn(3'd1, 32'h2B30_0000, 4'd15, 1, 0, 0);
        chk("t4_burst15", {28'd0, bus.hdr_burst}, 32'd15);
        txn(3'd1, 32'h0012_3400, 4'd15, 0, 0, 0);
        chk("t4_err_count2", {24'd0, err_count}, 32'd4);

        txn(3'd2, 32'h4500_0000, 4'd5, 0, 0, 1);
        txn(3'd1, 32'h0077_0000, 4'd6, 0, 0, 1);
        txn(3'd1, 32'h3C00_0000, 4'd2, 0, 0, 0);
        chk("t5_hdr_path", {25'd0, bus.hdr_path}, {25'd0, 7'h3C ^ 7'h1B});

        for (int i = 0; i < 150; i++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[31:24] = 8'h00;
            c = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'($urandom_range(1, 2));
            txn(c, a, 4'($urandom), $urandom_range(0, 3), 0, 0);
            if ($urandom_range(0, 3) == 0) begin @(posedge clock); #1; end
        end

        for (int i = 0; i < 260; i++) begin
            a = $urandom;
            a[31:24] = 8'h00;
            txn(3'($urandom_range(1, 2)), a, 4'd1, 0, 0, 0);
            if (i % 20 == 0) begin
                txn(3'd0, $urandom | 32'h0100_0000, 4'd1, 0, 0, 0);
                txn(3'd3, $urandom | 32'h0100_0000, 4'd1, 0, 0, 0);
            end
        end
        chk("t6_err_count_sat", {24'd0, err_count}, 32'd255);

        @(posedge clock); #1;
        run_chk = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got no completion expected completion");
        $fatal(1, "watchdog");
    end
endmodule
